mc_decoder: RTL and testbench
=============================

Name: mc_decoder

Overview:
- Multicycle control unit for the ARM-subset core. It replaces the single-cycle main decoder with a state machine that sequences fetch, decode, memory and execute steps over a shared memory port.
- Memory access is stretched by a mem_ready handshake, with a parametrised bus-wait timeout.
- ALU decode covers a wider op set (adds EOR and a shift op) on a parametrised control width.
- Sits between the instruction register and the multicycle datapath muxes and enables.

Parameters:
- REG_W, 4, register-index width of rd.
- PC_IDX, 15, register index that aliases the PC.
- ALU_CTRL_W, 3, alu_control width; must be at least 3.
- TIMEOUT, 16, maximum mem_ready wait cycles before a fault; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- op  in  2  instr[27:26], from the IR.
- funct  in  6  instr[25:20]; funct[5] is the immediate flag I, funct[4:1] is cmd, funct[0] is S (data-processing) or L (memory).
- rd  in  REG_W  destination register index.
- cond_ex  in  1  condition passed; gates every architectural write.
- mem_ready  in  1  memory completes the access this cycle.
- ir_write, pc_write, reg_w, mem_w  out  1  write enables.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- alu_src_a  out  1  ALU A select: 0 = Rn, 1 = PC.
- alu_src_b  out  2  ALU B select: 00 = reg, 01 = ExtImm, 10 = constant 4.
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result.
- imm_src, reg_src  out  2  extend select / register-read select; same encodings as the single-cycle decoder.
- alu_control  out  ALU_CTRL_W  ALU operation code.
- flag_w  out  2  flag write enables: [1] = NZ, [0] = CV.
- no_write  out  1  compare/test instruction; result is not written back.
- shift_flag  out  1  shift operation selected.
- fault  out  1  sticky fault indication.
- bus_err  out  1  sticky; the fault was caused by a mem_ready timeout.

Behaviour:
- While reset is high, every output is 0, state is FETCH, the wait counter is 0, and fault and bus_err are cleared.
- All outputs are combinational from state, the IR fields, cond_ex and mem_ready. Any output not listed for a state is 0.
- FETCH:
  - Drives adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10.
  - ir_write and pc_write equal mem_ready.
  - Moves to DECODE when mem_ready=1, otherwise stays in FETCH.
- DECODE:
  - Drives alu_src_a=1, alu_src_b=10, result_src=10 (computes PC+8).
  - Next state: op=01 goes to MEMADR; op=00 with I=0 goes to EXEC_R; op=00 with I=1 goes to EXEC_I; op=10 goes to BRANCH; op=11 goes to FAULT.
- MEMADR:
  - Drives alu_src_b=01, imm_src=01.
  - Moves to MEMRD if L=1, otherwise to MEMWR.
- MEMRD:
  - Drives adr_src=1.
  - Waits for mem_ready, then moves to MEMWB.
- MEMWB:
  - Drives result_src=01 and reg_w=cond_ex.
  - pc_write = cond_ex & (rd==PC_IDX).
  - Moves to FETCH.
- MEMWR:
  - Drives adr_src=1 and mem_w = cond_ex & mem_ready.
  - Waits for mem_ready, then moves to FETCH.
- EXEC_R / EXEC_I:
  - alu_src_b is 00 in EXEC_R and 01 in EXEC_I (with imm_src=00).
  - ALU decode is active; flag_w is gated by cond_ex.
  - Moves to ALUWB.
- ALUWB:
  - Drives result_src=00 and reg_w = cond_ex & ~no_write.
  - pc_write = cond_ex & ~no_write & (rd==PC_IDX).
  - Moves to FETCH.
- BRANCH:
  - Drives alu_src_b=01, imm_src=10, result_src=10.
  - pc_write=cond_ex; reg_w = cond_ex & funct[4] (BL link).
  - Moves to FETCH.
- FAULT:
  - fault=1; all enables are 0.
  - Leaves FAULT only on reset.
- ALU decode, active in EXEC states only; outside them alu_control=000, flag_w=0, no_write=0, shift_flag=0:
  - ADD 0100 → 000; SUB 0010 → 001; AND 0000 → 010; ORR 1100 → 011; EOR 0001 → 100; MOV/LSL 1101 → 101 with shift_flag=1.
  - CMP 1010 → 001; CMN 1011 → 000; TST 1000 → 010; all three set no_write=1.
  - Any other cmd is illegal: go to FAULT from EXEC instead of ALUWB, with no writes in that cycle.
- flag_w[1] = S.
- flag_w[0] = S & (alu_control is 000 or 001).
- Wait counter:
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - Clears on any state change.
  - When TIMEOUT≠0 and the count reaches TIMEOUT-1 with mem_ready still 0, the next state is FAULT and bus_err is set.
  - mem_ready=1 in that same cycle wins: the access completes normally.
- Reset in any state, including mid-wait, returns to FETCH on the next edge with no write pulse.

Optional Feature:
- Macro: MC_DECODER_PERF_EN.
- Defined: adds output instret [31:0], reset 0.
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH.
  - Wraps at 2^32.
  - Frozen in FAULT.
- Undefined: the port is absent and no counter logic is built.

Decomposition:
- Package mc_decoder_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, FAULT;
  - alu_control codes;
  - src-select encodings;
  - cmd constants.
- One combinational sub-module, mc_alu_decoder: inputs cmd, S, active; outputs alu_control, flag_w, no_write, shift_flag, illegal.

Test Plan:
- ADD r1 with S=1, cond_ex=1, mem_ready always 1 → states FETCH, DECODE, EXEC_R, ALUWB, FETCH; alu_control=000, flag_w=11, reg_w=1 in ALUWB.
- LDR with mem_ready low for 3 cycles in MEMRD → 3 stall cycles, then MEMWB with result_src=01 and reg_w=1; bus_err stays 0.
- STR with cond_ex=0 → mem_w stays 0 throughout; returns to FETCH.
- CMP (cmd=1010, S=1) → alu_control=001, flag_w=11, no_write=1, reg_w=0 in ALUWB.
- LDR to rd=15 → pc_write=1 in MEMWB.
- TIMEOUT=4 with mem_ready held 0 in FETCH → FAULT after 4 cycles; fault=1 and bus_err=1 until reset; reset then returns to FETCH with all outputs 0.
- cmd=0111 → FAULT with no reg_w pulse.
- With MC_DECODER_PERF_EN defined, 5 instructions executed → instret=5.

Source files
------------

// File: rtl/mc_decoder_pkg.sv
// rtl/mc_decoder_pkg.sv - states, ALU codes, select encodings and cmd constants for mc_decoder
package mc_decoder_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, FAULT
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;
  localparam logic       SRCA_RN    = 1'b0;
  localparam logic       SRCA_PC    = 1'b1;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] IMM_DP     = 2'b00;
  localparam logic [1:0] IMM_MEM    = 2'b01;
  localparam logic [1:0] IMM_BR     = 2'b10;

  // Datapath controls that are forced to zero together while reset is high.
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       reg_w;
    logic       mem_w;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] flag_w;
    logic       no_write;
    logic       shift_flag;
  } ctrl_t;

  function automatic logic cmd_is_test(input logic [3:0] cmd);
    return (cmd == CMD_TST) || (cmd == CMD_CMP) || (cmd == CMD_CMN);
  endfunction

endpackage

// File: rtl/mc_decoder_alu.sv
// rtl/mc_decoder_alu.sv - mc_alu_decoder: cmd/S to alu_control, flag enables and illegal-cmd detect
module mc_alu_decoder
  import mc_decoder_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [3:0]            cmd_i,
  input  logic                  s_i,
  input  logic                  active_i,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic [1:0]            flag_w_o,
  output logic                  no_write_o,
  output logic                  shift_flag_o,
  output logic                  illegal_o
);

  logic [2:0] code;
  logic       legal;
  logic       shift;

  always_comb begin
    code  = ALU_ADD;
    legal = 1'b1;
    shift = 1'b0;
    case (cmd_i)
      CMD_ADD, CMD_CMN: code = ALU_ADD;
      CMD_SUB, CMD_CMP: code = ALU_SUB;
      CMD_AND, CMD_TST: code = ALU_AND;
      CMD_ORR:          code = ALU_ORR;
      CMD_EOR:          code = ALU_EOR;
      CMD_MOV: begin
        code  = ALU_MOV;
        shift = 1'b1;
      end
      default:          legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_control_o = '0;
    flag_w_o      = 2'b00;
    no_write_o    = 1'b0;
    shift_flag_o  = 1'b0;
    illegal_o     = active_i & ~legal;
    if (active_i && legal) begin
      alu_control_o = ALU_CTRL_W'(code);
      flag_w_o      = {s_i, s_i & ((code == ALU_ADD) || (code == ALU_SUB))};
      no_write_o    = cmd_is_test(cmd_i);
      shift_flag_o  = shift;
    end
  end

endmodule

// File: rtl/mc_decoder.sv
// rtl/mc_decoder.sv - multicycle control FSM; MC_DECODER_PERF_EN adds the instret counter
module mc_decoder
  import mc_decoder_pkg::*;
#(
  parameter int REG_W      = 4,
  parameter int PC_IDX     = 15,
  parameter int ALU_CTRL_W = 3,
  parameter int TIMEOUT    = 16
) (
`ifdef MC_DECODER_PERF_EN
  output logic [31:0]           instret,
`endif
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [REG_W-1:0]      rd,
  input  logic                  cond_ex,
  input  logic                  mem_ready,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_w,
  output logic                  mem_w,
  output logic                  adr_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            flag_w,
  output logic                  no_write,
  output logic                  shift_flag,
  output logic                  fault,
  output logic                  bus_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
  ctrl_t             ctrl;
  logic [ALU_CTRL_W-1:0] alu_ctrl_c;

  logic [3:0] cmd;
  logic       i_bit, s_bit, rd_is_pc, exec, waiting, timeout_hit;
  logic [ALU_CTRL_W-1:0] dec_alu;
  logic [1:0] dec_flag_w;
  logic       dec_no_write, dec_shift, dec_illegal;

  assign cmd      = funct[4:1];
  assign i_bit    = funct[5];
  assign s_bit    = funct[0];
  assign rd_is_pc = (rd == REG_W'(PC_IDX));
  assign exec     = (state_q == EXEC_R) || (state_q == EXEC_I);
  assign waiting  = ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR)) && !mem_ready;
  assign timeout_hit = (TIMEOUT != 0) && waiting && (wait_q == WAIT_LAST);

  mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .cmd_i        (cmd),
    .s_i          (s_bit),
    .active_i     (exec),
    .alu_control_o(dec_alu),
    .flag_w_o     (dec_flag_w),
    .no_write_o   (dec_no_write),
    .shift_flag_o (dec_shift),
    .illegal_o    (dec_illegal)
  );

  always_comb begin
    ctrl       = '0;
    alu_ctrl_c = '0;
    state_d    = state_q;
    case (state_q)
      FETCH: begin
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        case (op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = i_bit ? EXEC_I : EXEC_R;
          OP_BR:   state_d = BRANCH;
          default: state_d = FAULT;
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_MEM;
        state_d        = s_bit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.adr_src = ADR_ALUOUT;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = cond_ex;
        ctrl.pc_write   = cond_ex & rd_is_pc;
        state_d         = FETCH;
      end
      MEMWR: begin
        ctrl.adr_src = ADR_ALUOUT;
        ctrl.mem_w   = cond_ex & mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXEC_R, EXEC_I: begin
        ctrl.alu_src_b  = (state_q == EXEC_I) ? SRCB_IMM : SRCB_REG;
        ctrl.imm_src    = IMM_DP;
        alu_ctrl_c      = dec_alu;
        ctrl.flag_w     = cond_ex ? dec_flag_w : 2'b00;
        ctrl.no_write   = dec_no_write;
        ctrl.shift_flag = dec_shift;
        state_d         = dec_illegal ? FAULT : ALUWB;
      end
      ALUWB: begin
        // The IR is stable here, so the compare/test class is re-derived from cmd.
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = cond_ex & ~cmd_is_test(cmd);
        ctrl.pc_write   = cond_ex & ~cmd_is_test(cmd) & rd_is_pc;
        state_d         = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.imm_src    = IMM_BR;
        ctrl.result_src = RES_ALU;
        ctrl.pc_write   = cond_ex;
        ctrl.reg_w      = cond_ex & funct[4];
        state_d         = FETCH;
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    if (timeout_hit) state_d = FAULT;
  end

  always_comb begin
    bus_err_d = bus_err_q | timeout_hit;
    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_q + CNT_W'(1);
    else                    wait_d = wait_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign ir_write    = ~reset & ctrl.ir_write;
  assign pc_write    = ~reset & ctrl.pc_write;
  assign reg_w       = ~reset & ctrl.reg_w;
  assign mem_w       = ~reset & ctrl.mem_w;
  assign adr_src     = ~reset & ctrl.adr_src;
  assign alu_src_a   = ~reset & ctrl.alu_src_a;
  assign alu_src_b   = reset ? 2'b00 : ctrl.alu_src_b;
  assign result_src  = reset ? 2'b00 : ctrl.result_src;
  assign imm_src     = reset ? 2'b00 : ctrl.imm_src;
  assign reg_src     = reset ? 2'b00 : ctrl.reg_src;
  assign flag_w      = reset ? 2'b00 : ctrl.flag_w;
  assign no_write    = ~reset & ctrl.no_write;
  assign shift_flag  = ~reset & ctrl.shift_flag;
  assign alu_control = reset ? '0 : alu_ctrl_c;
  assign fault       = ~reset & (state_q == FAULT);
  assign bus_err     = ~reset & bus_err_q;

`ifdef MC_DECODER_PERF_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if ((state_d == FETCH) &&
                 ((state_q == MEMWB) || (state_q == MEMWR) ||
                  (state_q == ALUWB) || (state_q == BRANCH))) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mc_decoder.sv
// tb/tb_mc_decoder.sv - directed self-checking bench for mc_decoder (TIMEOUT=4)
module tb_mc_decoder;

  logic       clk = 1'b0;
  logic       reset, cond_ex, mem_ready;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       ir_write, pc_write, reg_w, mem_w, adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src, imm_src, reg_src, flag_w;
  logic [2:0] alu_control;
  logic       no_write, shift_flag, fault, bus_err;
`ifdef MC_DECODER_PERF_EN
  logic [31:0] instret;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_decoder #(.REG_W(4), .PC_IDX(15), .ALU_CTRL_W(3), .TIMEOUT(4)) dut (
`ifdef MC_DECODER_PERF_EN
    .instret    (instret),
`endif
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .rd         (rd),
    .cond_ex    (cond_ex),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .reg_src    (reg_src),
    .alu_control(alu_control),
    .flag_w     (flag_w),
    .no_write   (no_write),
    .shift_flag (shift_flag),
    .fault      (fault),
    .bus_err    (bus_err)
  );

  logic [22:0] obs;
  assign obs = {ir_write, pc_write, reg_w, mem_w, adr_src, alu_src_a, alu_src_b, result_src,
                imm_src, reg_src, alu_control, flag_w, no_write, shift_flag, fault, bus_err};

  function automatic logic [22:0] ev(input logic ir, pc, rw, mw, adr, asa,
                                     input logic [1:0] asb, rs, imm,
                                     input logic [2:0] alu, input logic [1:0] fw,
                                     input logic nw, sh, f, be);
    return {ir, pc, rw, mw, adr, asa, asb, rs, imm, 2'b00, alu, fw, nw, sh, f, be};
  endfunction

  task automatic chk(input string tag, input logic [22:0] exp_v);
    #1;
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [22:0] ZERO, F_RDY, F_STALL, DEC, MADR, ADR1;

  initial begin
    ZERO    = ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0,0);
    F_RDY   = ev(1,1,0,0,0,1,2'b10,2'b10,2'b00,3'b000,2'b00,0,0,0,0);
    F_STALL = ev(0,0,0,0,0,1,2'b10,2'b10,2'b00,3'b000,2'b00,0,0,0,0);
    DEC     = ev(0,0,0,0,0,1,2'b10,2'b10,2'b00,3'b000,2'b00,0,0,0,0);
    MADR    = ev(0,0,0,0,0,0,2'b01,2'b00,2'b01,3'b000,2'b00,0,0,0,0);
    ADR1    = ev(0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0,0);

    reset = 1'b1; mem_ready = 1'b1; cond_ex = 1'b1; op = 2'b00; funct = 6'b0; rd = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", ZERO);
`ifdef MC_DECODER_PERF_EN
    chk_cnt("instret_reset", instret, 32'd0);
`endif
    reset = 1'b0;

    // ADD r1, S=1
    op = 2'b00; funct = 6'b001001; rd = 4'd1;
    chk("add_fetch", F_RDY); step;
    chk("add_decode", DEC); step;
    chk("add_exec", ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b11,0,0,0,0)); step;
    chk("add_aluwb", ev(0,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0,0)); step;

    // LDR r2 with three stall cycles in MEMRD
    op = 2'b01; funct = 6'b011001; rd = 4'd2;
    chk("ldr_fetch", F_RDY); step;
    chk("ldr_decode", DEC); step;
    chk("ldr_memadr", MADR); step;
    mem_ready = 1'b0;
    chk("ldr_stall1", ADR1); step;
    chk("ldr_stall2", ADR1); step;
    chk("ldr_stall3", ADR1); step;
    mem_ready = 1'b1;
    chk("ldr_memrd_done", ADR1); step;
    chk("ldr_memwb", ev(0,0,1,0,0,0,2'b00,2'b01,2'b00,3'b000,2'b00,0,0,0,0)); step;

    // STR with cond_ex=0
    op = 2'b01; funct = 6'b011000; rd = 4'd3; cond_ex = 1'b0;
    chk("str_nc_fetch", F_RDY); step;
    chk("str_nc_decode", DEC); step;
    chk("str_nc_memadr", MADR); step;
    chk("str_nc_memwr", ADR1); step;
    cond_ex = 1'b1;

    // STR with cond_ex=1 and one stall
    chk("str_fetch", F_RDY); step;
    chk("str_decode", DEC); step;
    chk("str_memadr", MADR); step;
    mem_ready = 1'b0;
    chk("str_memwr_stall", ADR1); step;
    mem_ready = 1'b1;
    chk("str_memwr_done", ev(0,0,0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0,0)); step;

    // CMP, S=1
    op = 2'b00; funct = 6'b010101; rd = 4'd0;
    chk("cmp_fetch", F_RDY); step;
    chk("cmp_decode", DEC); step;
    chk("cmp_exec", ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b001,2'b11,1,0,0,0)); step;
    chk("cmp_aluwb", ZERO); step;
`ifdef MC_DECODER_PERF_EN
    chk_cnt("instret_after_5", instret, 32'd5);
`endif

    // LDR to PC
    op = 2'b01; funct = 6'b011001; rd = 4'd15;
    chk("ldrpc_fetch", F_RDY); step;
    chk("ldrpc_decode", DEC); step;
    chk("ldrpc_memadr", MADR); step;
    chk("ldrpc_memrd", ADR1); step;
    chk("ldrpc_memwb", ev(0,1,1,0,0,0,2'b00,2'b01,2'b00,3'b000,2'b00,0,0,0,0)); step;

    // EOR immediate, S=0
    op = 2'b00; funct = 6'b100010; rd = 4'd3;
    chk("eori_fetch", F_RDY); step;
    chk("eori_decode", DEC); step;
    chk("eori_exec", ev(0,0,0,0,0,0,2'b01,2'b00,2'b00,3'b100,2'b00,0,0,0,0)); step;
    chk("eori_aluwb", ev(0,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0,0)); step;

    // BL
    op = 2'b10; funct = 6'b010000; rd = 4'd0;
    chk("bl_fetch", F_RDY); step;
    chk("bl_decode", DEC); step;
    chk("bl_branch", ev(0,1,1,0,0,0,2'b01,2'b10,2'b10,3'b000,2'b00,0,0,0,0)); step;

    // MOV/LSL, S=1
    op = 2'b00; funct = 6'b011011; rd = 4'd4;
    chk("mov_fetch", F_RDY); step;
    chk("mov_decode", DEC); step;
    chk("mov_exec", ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b101,2'b10,0,1,0,0)); step;
    chk("mov_aluwb", ev(0,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0,0)); step;
`ifdef MC_DECODER_PERF_EN
    chk_cnt("instret_after_9", instret, 32'd9);
`endif

    // Illegal cmd 0111
    op = 2'b00; funct = 6'b001110; rd = 4'd5;
    chk("ill_fetch", F_RDY); step;
    chk("ill_decode", DEC); step;
    chk("ill_exec", ZERO); step;
    chk("ill_fault", ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,1,0)); step;
    step;
    chk("ill_fault_held", ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,1,0));
`ifdef MC_DECODER_PERF_EN
    chk_cnt("instret_frozen", instret, 32'd9);
`endif
    reset = 1'b1;
    chk("ill_reset_out", ZERO); step;
    reset = 1'b0;
    chk("ill_reset_fetch", F_RDY);
`ifdef MC_DECODER_PERF_EN
    chk_cnt("instret_cleared", instret, 32'd0);
`endif

    // Bus-wait timeout in FETCH
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_stall%0d", i), F_STALL); step;
    end
    chk("to_fault", ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,1,1)); step;
    step;
    chk("to_fault_sticky", ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,1,1));
    reset = 1'b1;
    chk("to_reset_out", ZERO); step;
    chk("to_reset_held", ZERO);
    reset = 1'b0; mem_ready = 1'b1;
    chk("to_reset_fetch", F_RDY);

    // mem_ready on the last permitted wait cycle completes normally
    op = 2'b11; funct = 6'b000000;
    mem_ready = 1'b0;
    step; step; step;
    mem_ready = 1'b1;
    chk("ready_wins_fetch", F_RDY); step;
    chk("ready_wins_decode", DEC); step;
    chk("op11_fault", ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,1,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
